// File: rtl/intersection_sched_if.sv
// rtl/intersection_sched_if.sv - control and light-unit handshake bundle for intersection_sched
interface intersection_sched_if;
  logic start;
  logic stop;
  logic ped_req;
  logic fault_clr;
  logic done_a;
  logic done_b;
  logic enable_a;
  logic clear_a;
  logic enable_b;
  logic clear_b;
  logic ped_walk;
  logic busy;
  logic fault;

  modport master (
    output start, stop, ped_req, fault_clr, done_a, done_b,
    input  enable_a, clear_a, enable_b, clear_b, ped_walk, busy, fault
  );

  modport slave (
    input  start, stop, ped_req, fault_clr, done_a, done_b,
    output enable_a, clear_a, enable_b, clear_b, ped_walk, busy, fault
  );
endinterface

// File: rtl/intersection_sched.sv
// rtl/intersection_sched.sv - A/B approach sequencer with all-red clearance, walk phase and fault watchdog
module intersection_sched #(
  parameter int DIV_FACTOR  = 10,
  parameter int ALLRED_SEC  = 2,
  parameter int PED_SEC     = 5,
  parameter int TIMEOUT_SEC = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  intersection_sched_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    RUN_A,
    CLR_A,
    ALLRED_A,
    RUN_B,
    CLR_B,
    ALLRED_B,
    PED,
    FAULT
  } state_t;

  localparam logic [7:0] DIV_LAST     = 8'(DIV_FACTOR - 1);
  localparam logic [7:0] ALLRED_LAST  = 8'(ALLRED_SEC - 1);
  localparam logic [7:0] PED_LAST     = 8'(PED_SEC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_SEC - 1);

  state_t     state;
  state_t     state_d;
  logic [7:0] presc;
  logic [7:0] tick_cnt;
  logic [7:0] phase_last;
  logic       timed;
  logic       tick;
  logic       expire;
  logic       stop_l;
  logic       ped_l;
  logic       last_b;

  // Phase length selection; only timed states run the prescaler.
  always_comb begin
    timed      = 1'b0;
    phase_last = TIMEOUT_LAST;
    case (state)
      RUN_A, RUN_B: begin
        timed      = 1'b1;
        phase_last = TIMEOUT_LAST;
      end
      ALLRED_A, ALLRED_B: begin
        timed      = 1'b1;
        phase_last = ALLRED_LAST;
      end
      PED: begin
        timed      = 1'b1;
        phase_last = PED_LAST;
      end
      default: begin
        timed      = 1'b0;
        phase_last = TIMEOUT_LAST;
      end
    endcase
  end

  assign tick   = timed && (presc == DIV_LAST);
  assign expire = tick && (tick_cnt == phase_last);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) state_d = RUN_A;
      end
      RUN_A: begin
        if (bus.done_a)   state_d = CLR_A;
        else if (expire)  state_d = FAULT;
      end
      CLR_A: state_d = ALLRED_A;
      ALLRED_A: begin
        if (expire) begin
          if (stop_l)     state_d = IDLE;
          else if (ped_l) state_d = PED;
          else            state_d = RUN_B;
        end
      end
      RUN_B: begin
        if (bus.done_b)   state_d = CLR_B;
        else if (expire)  state_d = FAULT;
      end
      CLR_B: state_d = ALLRED_B;
      ALLRED_B: begin
        if (expire) begin
          if (stop_l)     state_d = IDLE;
          else if (ped_l) state_d = PED;
          else            state_d = RUN_A;
        end
      end
      PED: begin
        if (expire) state_d = last_b ? RUN_A : RUN_B;
      end
      FAULT: begin
        if (bus.fault_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Every state change restarts the phase timer from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= 8'd0;
      tick_cnt <= 8'd0;
    end else if (state_d != state || !timed) begin
      presc    <= 8'd0;
      tick_cnt <= 8'd0;
    end else if (tick) begin
      presc    <= 8'd0;
      tick_cnt <= tick_cnt + 8'd1;
    end else begin
      presc    <= presc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_l <= 1'b0;
      ped_l  <= 1'b0;
      last_b <= 1'b0;
    end else begin
      if (state_d == IDLE)
        stop_l <= 1'b0;
      else if (bus.stop && state != IDLE && state != FAULT)
        stop_l <= 1'b1;

      // Entering the walk phase consumes the request; requests during walk are dropped.
      if (state_d == PED && state != PED)
        ped_l <= 1'b0;
      else if (bus.ped_req && state != PED && state != FAULT)
        ped_l <= 1'b1;

      if (state == RUN_A)      last_b <= 1'b0;
      else if (state == RUN_B) last_b <= 1'b1;
    end
  end

  assign bus.enable_a = (state == RUN_A);
  assign bus.clear_a  = (state == CLR_A);
  assign bus.enable_b = (state == RUN_B);
  assign bus.clear_b  = (state == CLR_B);
  assign bus.ped_walk = (state == PED);
  assign bus.busy     = (state != IDLE);
  assign bus.fault    = (state == FAULT);

endmodule

// File: tb/tb_intersection_sched.sv
// tb/tb_intersection_sched.sv - self-checking bench for intersection_sched
module tb_intersection_sched;

  // Output vector order: {enable_a, clear_a, enable_b, clear_b, ped_walk, busy, fault}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_RA   = 7'b1000010;
  localparam logic [6:0] O_CA   = 7'b0100010;
  localparam logic [6:0] O_AR   = 7'b0000010;
  localparam logic [6:0] O_RB   = 7'b0010010;
  localparam logic [6:0] O_CB   = 7'b0001010;
  localparam logic [6:0] O_PED  = 7'b0000110;
  localparam logic [6:0] O_FLT  = 7'b0000011;

  // Input vector order: {start, stop, ped_req, fault_clr, done_a, done_b}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_START = 6'b100000;
  localparam logic [5:0] I_STOP  = 6'b010000;
  localparam logic [5:0] I_PED   = 6'b001000;
  localparam logic [5:0] I_FCLR  = 6'b000100;
  localparam logic [5:0] I_DA    = 6'b000010;
  localparam logic [5:0] I_DB    = 6'b000001;

  typedef struct {
    string      name;
    logic [5:0] in;
    int         reps;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb[$];
  int         checks   = 0;
  int         failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  intersection_sched_if bus();

  intersection_sched #(
    .DIV_FACTOR (4),
    .ALLRED_SEC (2),
    .PED_SEC    (3),
    .TIMEOUT_SEC(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [6:0] obs();
    return {bus.enable_a, bus.clear_a, bus.enable_b, bus.clear_b,
            bus.ped_walk, bus.busy, bus.fault};
  endfunction

  task automatic drive(input logic [5:0] in);
    {bus.start, bus.stop, bus.ped_req, bus.fault_clr, bus.done_a, bus.done_b} = in;
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (en_a clr_a en_b clr_b walk busy fault)",
               name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare at the falling edge.
  task automatic cycle(input string name, input logic [5:0] in, input logic [6:0] exp);
    logic [6:0] e;
    drive(in);
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check(name, obs(), e);
  endtask

  function automatic void add(input string name, input logic [5:0] in,
                              input int reps, input logic [6:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.reps = reps;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    // Start+stop together in IDLE must be refused.
    add("t6_start_stop_idle", I_START | I_STOP, 3,  O_IDLE);
    // Basic A -> all-red -> B; done_a arrives on the 20th RUN_A cycle, the same cycle
    // the 5-tick watchdog expires, so this also covers the done/timeout collision.
    add("t1_start",           I_START,          1,  O_RA);
    add("t1_run_a",           I_NONE,           19, O_RA);
    add("t1_done_a_collide",  I_DA,             1,  O_CA);
    add("t1_allred_a",        I_NONE,           8,  O_AR);
    add("t1_run_b",           I_NONE,           5,  O_RB);
    add("t1_done_b",          I_DB,             1,  O_CB);
    add("t1_allred_b",        I_NONE,           8,  O_AR);
    // Pedestrian request latched during RUN_A; done_b in RUN_A must be ignored.
    add("t2_run_a",           I_NONE,           1,  O_RA);
    add("t2_ped_req",         I_PED,            1,  O_RA);
    add("t2_done_b_ignored",  I_DB,             2,  O_RA);
    add("t2_done_a",          I_DA,             1,  O_CA);
    add("t2_allred_a",        I_NONE,           8,  O_AR);
    add("t2_ped_walk",        I_NONE,           12, O_PED);
    add("t2_run_b_after_ped", I_NONE,           1,  O_RB);
    // Stop latched during RUN_B returns to IDLE after all-red; start works again.
    add("t3_stop",            I_STOP,           1,  O_RB);
    add("t3_run_b",           I_NONE,           2,  O_RB);
    add("t3_done_b",          I_DB,             1,  O_CB);
    add("t3_allred_b",        I_NONE,           8,  O_AR);
    add("t3_idle",            I_NONE,           3,  O_IDLE);
    add("t3_restart",         I_START,          1,  O_RA);
    // Watchdog: no done for 20 cycles after RUN_A entry.
    add("t4_run_a_wait",      I_NONE,           19, O_RA);
    add("t4_fault",           I_NONE,           1,  O_FLT);
    add("t4_fault_ignores",   I_START | I_STOP | I_PED | I_DA, 3, O_FLT);
    add("t4_fault_clr",       I_FCLR,           1,  O_IDLE);
    add("t4_idle",            I_NONE,           2,  O_IDLE);
    // Requests seen in FAULT must not have latched: A -> all-red -> B directly.
    add("t4_post_start",      I_START,          1,  O_RA);
    add("t4_post_done_a",     I_DA,             1,  O_CA);
    add("t4_post_allred",     I_NONE,           8,  O_AR);
    add("t4_post_run_b",      I_NONE,           1,  O_RB);

    drive(I_NONE);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", obs(), O_IDLE);
    rst_n = 1'b1;
    cycle("reset_release_idle", I_NONE, O_IDLE);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++)
        cycle(vecs[i].name, vecs[i].in, vecs[i].exp);
    end

    // Asynchronous reset in the middle of the walk phase, with stop freshly latched.
    cycle("t5_ped_req", I_PED, O_RB);
    cycle("t5_done_b", I_DB, O_CB);
    for (int r = 0; r < 8; r++) cycle("t5_allred_b", I_NONE, O_AR);
    cycle("t5_ped_walk", I_STOP, O_PED);
    cycle("t5_ped_walk", I_NONE, O_PED);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset_outputs", obs(), O_IDLE);
    @(negedge clk);
    check("t5_reset_held", obs(), O_IDLE);
    rst_n = 1'b1;
    cycle("t5_idle_after_reset", I_NONE, O_IDLE);
    cycle("t5_restart", I_START, O_RA);
    cycle("t5_done_a", I_DA, O_CA);
    for (int r = 0; r < 8; r++) cycle("t5_allred_a", I_NONE, O_AR);
    cycle("t5_no_stale_latch", I_NONE, O_RB);

    drive(I_NONE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
